wbu_commit: RTL and testbench
=============================

Name: wbu_commit

Overview:
Parametrised write-back/commit stage that owns the architectural GPR file and machine CSRs.
- Accepts one retiring instruction per cycle on a valid/ready handshake.
- Provides combinational read ports with optional same-cycle bypass.
- Tracks in-flight destination registers with a per-register scoreboard.
- Handles ecall/mret trap updates and redirects, latches ebreak halt, and counts retired instructions.

Parameters:
XLEN, 32, data width of GPRs/CSRs
NREG, 32, number of GPRs (16 for RV32E or 32); index width fixed at 5
BYPASS, 1, 1 = read ports forward the same-cycle committing write
SB_W, 2, scoreboard counter width per register (max in-flight writes = 2^SB_W-1)
CAUSE_ECALL, 11, value written to mcause on ecall

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  retiring instruction present
in_ready  out  1  stage can accept
rd  in  5  GPR destination
reg_en  in  1  GPR write enable
wd  in  XLEN  GPR write data
csr_rd  in  2  CSR destination (0 mcause, 1 mepc, 2 mstatus, 3 mtvec)
csr_en  in  1  CSR write enable
csr_wd  in  XLEN  CSR write data
ecall, mret, ebreak  in  1 each  instruction class flags
pc, pc_next, inst  in  XLEN each  retiring instruction info
iss_valid  in  1  issue stage allocates a destination
iss_rd  in  5  allocated destination
iss_ready  out  1  allocation allowed
rs1, rs2  in  5  GPR read addresses
csr_rs  in  2  CSR read address
rsa, rsb, csra  out  XLEN  read data
rs1_busy, rs2_busy  out  1  scoreboard counter of rs1/rs2 nonzero
commit_valid  out  1  registered commit pulse
commit_pc, commit_pc_next, commit_inst  out  XLEN  registered commit info
redirect_valid  out  1  registered trap/return redirect pulse
redirect_pc  out  XLEN  redirect target
halted  out  1  ebreak retired
retire_cnt  out  64  retired instruction count

Behaviour:
- Reset: all GPRs, CSRs, scoreboard counters, and the retire counter = 0; state RUN. Every registered output = 0. in_ready and iss_ready = 0 while rst is high.
- FSM has two states, RUN and HALT.
  - RUN: in_ready = 1. An accept is in_valid && in_ready.
  - Accept with ebreak: the instruction commits normally, then the FSM moves to HALT.
  - HALT: in_ready = 0, iss_ready = 0, halted = 1. HALT is left only by rst, including rst asserted mid-operation.
- GPR write on accept with reg_en: regs[rd] <= wd, except:
  - rd = 0 is ignored; x0 always reads 0.
  - With NREG=16, rd >= 16 writes are ignored and reads of those addresses return 0.
- CSR write on accept with csr_en: csr[csr_rd] <= csr_wd.
- ecall on accept:
  - mepc <= pc, mcause <= CAUSE_ECALL.
  - mstatus.MPIE(7) <= MIE(3), then MIE <= 0.
  - These trap updates win over a same-beat csr_en write to the same CSR.
- mret on accept: mstatus.MIE <= MPIE, MPIE <= 1.
- Redirect: one cycle after an ecall/mret accept, redirect_valid = 1.
  - ecall: redirect_pc = mtvec after any same-beat csr_en write.
  - mret: redirect_pc = mepc.
  - ecall and mret together: treated as ecall.
- Commit: one cycle after each accept, commit_valid = 1 with the latched pc/pc_next/inst. Otherwise commit_valid = 0 and the info outputs hold their previous values.
- retire_cnt: +1 per accept, wraps modulo 2^64.
- Reads:
  - rsa/rsb/csra are combinational from the arrays.
  - With BYPASS=1, an accept in the same cycle with reg_en, rd == rs1 and rd != 0 drives rsa = wd; rsb likewise.
  - csra is bypassed from csr_wd for csr_en writes only. Trap-induced CSR changes are visible the next cycle.
- Scoreboard, one SB_W-bit counter per register:
  - iss_valid && iss_ready && iss_rd != 0 increments cnt[iss_rd].
  - Accept with reg_en && rd != 0 decrements cnt[rd].
  - Increment and decrement on the same register in the same cycle leave it unchanged.
  - iss_ready = RUN && !(iss_valid && cnt[iss_rd] == max).
  - A decrement at 0 is an upstream error: the counter saturates at 0 and the bench asserts it never occurs.
- rs*_busy reflects the counter before this cycle's update. Bypass covers the forwarded value.

Decomposition:
- Package wbu_pkg holds:
  - CSR index constants (CSR_MCAUSE=0, CSR_MEPC=1, CSR_MSTATUS=2, CSR_MTVEC=3).
  - mstatus bit positions MIE=3 and MPIE=7.
  - CAUSE_ECALL default.
  - State enum {RUN, HALT}.
- One sub-module, wbu_scoreboard (NREG, SB_W): counters, iss_ready, busy lookup.
- Register arrays, trap logic and the FSM stay in wbu_commit.

Test Plan:
1. Reset, then accept reg_en rd=5 wd=0x1234 with rs1=5 the same cycle (BYPASS=1) -> rsa=0x1234 that cycle. Next cycle regs[5]=0x1234, commit_valid=1, retire_cnt=1.
2. Write rd=0 wd=0xFFFF_FFFF -> rsa for rs1=0 stays 0. With NREG=16, rd=20 write is ignored and reads 0.
3. csr_en mtvec=0x8000_0100, then ecall at pc=0x8000_0040 with mstatus.MIE=1 -> next cycle redirect_valid=1, redirect_pc=0x8000_0100, mepc=0x8000_0040, mcause=11, mstatus MIE=0/MPIE=1.
4. mret after case 3 -> redirect_pc=0x8000_0040, MIE=1, MPIE=1.
5. Issue rd=7 three times (SB_W=2) -> cnt=3, rs1_busy=1. A fourth issue of rd=7 gives iss_ready=0. Issue rd=7 plus commit rd=7 in one cycle leaves cnt unchanged.
6. Accept ebreak with in_valid held high -> commit_valid once, halted=1, in_ready=0, retire_cnt frozen. Assert rst -> halted=0, all state cleared.

Source files
------------

// File: rtl/wbu_pkg.sv
// Shared constants, state encoding and helpers for the write-back/commit stage.
// CSR indices and mstatus bit positions match the machine-mode subset kept here.
package wbu_pkg;

    localparam logic [1:0] CSR_MCAUSE  = 2'd0;
    localparam logic [1:0] CSR_MEPC    = 2'd1;
    localparam logic [1:0] CSR_MSTATUS = 2'd2;
    localparam logic [1:0] CSR_MTVEC   = 2'd3;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam int CAUSE_ECALL_DEF = 11;

    typedef enum logic {RUN, HALT} state_t;

    // True for a writable GPR index: never x0, and below NREG for RV32E builds.
    function automatic logic gpr_ok(input logic [4:0] a, input int nreg);
        return (a != 5'd0) && ((nreg > 31) || (a < nreg[4:0]));
    endfunction

endpackage

// File: rtl/wbu_scoreboard.sv
// Per-register in-flight write counters: issue increments, commit decrements.
// Allocation is refused while the addressed counter is saturated.
module wbu_scoreboard
    import wbu_pkg::*;
#(
    parameter int NREG = 32,
    parameter int SB_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       iss_valid,
    input  logic [4:0] iss_rd,
    input  logic       dec_en,
    input  logic [4:0] dec_rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    output logic       iss_ready,
    output logic       rs1_busy,
    output logic       rs2_busy
);

    localparam logic [SB_W-1:0] CNT_MAX = '1;

    logic [SB_W-1:0] cnt [32];
    logic            inc;
    logic            dec;

    assign iss_ready = run && !(iss_valid && cnt[iss_rd] == CNT_MAX);
    assign inc       = iss_valid && iss_ready && gpr_ok(iss_rd, NREG);
    assign dec       = dec_en && gpr_ok(dec_rd, NREG);

    // Busy reflects the counter before this cycle's update; bypass covers the rest.
    assign rs1_busy = cnt[rs1] != '0;
    assign rs2_busy = cnt[rs2] != '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (inc && iss_rd == 5'(i) && !(dec && dec_rd == 5'(i)))
                    cnt[i] <= cnt[i] + SB_W'(1);
                else if (dec && dec_rd == 5'(i) && !(inc && iss_rd == 5'(i)) && cnt[i] != '0)
                    cnt[i] <= cnt[i] - SB_W'(1);
            end
        end
    end

endmodule

// File: rtl/wbu_commit.sv
// Write-back/commit stage owning the GPR file, machine CSRs, trap redirects and halt.
// Commit and redirect outputs are registered one cycle after the accepting beat.
module wbu_commit
    import wbu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NREG        = 32,
    parameter int BYPASS      = 1,
    parameter int SB_W        = 2,
    parameter int CAUSE_ECALL = CAUSE_ECALL_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      rd,
    input  logic            reg_en,
    input  logic [XLEN-1:0] wd,
    input  logic [1:0]      csr_rd,
    input  logic            csr_en,
    input  logic [XLEN-1:0] csr_wd,
    input  logic            ecall,
    input  logic            mret,
    input  logic            ebreak,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_next,
    input  logic [XLEN-1:0] inst,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    output logic            iss_ready,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [1:0]      csr_rs,
    output logic [XLEN-1:0] rsa,
    output logic [XLEN-1:0] rsb,
    output logic [XLEN-1:0] csra,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc,
    output logic [XLEN-1:0] commit_pc_next,
    output logic [XLEN-1:0] commit_inst,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            halted,
    output logic [63:0]     retire_cnt
);

    state_t          state, state_nxt;
    logic [XLEN-1:0] regs    [32];
    logic [XLEN-1:0] csr     [4];
    logic [XLEN-1:0] csr_nxt [4];
    logic            accept;
    logic            wr_gpr;
    logic            run;

    assign run      = !rst && state == RUN;
    assign in_ready = run;
    assign halted   = state == HALT;
    assign accept   = in_valid && in_ready;
    assign wr_gpr   = accept && reg_en && gpr_ok(rd, NREG);

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == RUN && accept && ebreak) state_nxt = HALT;
    end

    // Trap side effects are layered over the software write so they take priority.
    always_comb begin
        csr_nxt = csr;
        if (csr_en) csr_nxt[csr_rd] = csr_wd;
        if (ecall) begin
            csr_nxt[CSR_MEPC]                     = pc;
            csr_nxt[CSR_MCAUSE]                   = XLEN'(CAUSE_ECALL);
            csr_nxt[CSR_MSTATUS][MSTATUS_MPIE]    = csr_nxt[CSR_MSTATUS][MSTATUS_MIE];
            csr_nxt[CSR_MSTATUS][MSTATUS_MIE]     = 1'b0;
        end else if (mret) begin
            csr_nxt[CSR_MSTATUS][MSTATUS_MIE]     = csr_nxt[CSR_MSTATUS][MSTATUS_MPIE];
            csr_nxt[CSR_MSTATUS][MSTATUS_MPIE]    = 1'b1;
        end
    end

    always_comb begin
        rsa  = gpr_ok(rs1, NREG) ? regs[rs1] : '0;
        rsb  = gpr_ok(rs2, NREG) ? regs[rs2] : '0;
        csra = csr[csr_rs];
        if (BYPASS != 0) begin
            if (wr_gpr && rd == rs1)                  rsa  = wd;
            if (wr_gpr && rd == rs2)                  rsb  = wd;
            if (accept && csr_en && csr_rd == csr_rs) csra = csr_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            for (int i = 0; i < 4; i++)  csr[i]  <= '0;
            commit_valid   <= 1'b0;
            commit_pc      <= '0;
            commit_pc_next <= '0;
            commit_inst    <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            retire_cnt     <= '0;
        end else begin
            commit_valid   <= accept;
            redirect_valid <= accept && (ecall || mret);
            if (accept) begin
                if (wr_gpr) regs[rd] <= wd;
                csr            <= csr_nxt;
                commit_pc      <= pc;
                commit_pc_next <= pc_next;
                commit_inst    <= inst;
                retire_cnt     <= retire_cnt + 64'd1;
                if (ecall)     redirect_pc <= csr_nxt[CSR_MTVEC];
                else if (mret) redirect_pc <= csr_nxt[CSR_MEPC];
            end
        end
    end

    wbu_scoreboard #(.NREG(NREG), .SB_W(SB_W)) u_sb (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .dec_en    (accept && reg_en),
        .dec_rd    (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .iss_ready (iss_ready),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy)
    );

endmodule

// File: tb/tb_wbu_commit.sv
// Directed bench for wbu_commit: one 32-register and one 16-register instance share stimulus.
module tb_wbu_commit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, reg_en, csr_en, ecall, mret, ebreak, iss_valid;
    logic [4:0]  rd, iss_rd, rs1, rs2;
    logic [1:0]  csr_rd, csr_rs;
    logic [31:0] wd, csr_wd, pc, pc_next, inst;

    logic        in_ready, iss_ready, rs1_busy, rs2_busy, commit_valid, redirect_valid, halted;
    logic [31:0] rsa, rsb, csra, commit_pc, commit_pc_next, commit_inst, redirect_pc;
    logic [63:0] retire_cnt;

    logic        x_in_ready, x_iss_ready, x_rs1_busy, x_rs2_busy, x_commit_valid, x_redirect_valid, x_halted;
    logic [31:0] x_rsa, x_rsb, x_csra, x_commit_pc, x_commit_pc_next, x_commit_inst, x_redirect_pc;
    logic [63:0] x_retire_cnt;

    int tests  = 0;
    int failed = 0;
    int sb_model [32];

    always #5 clk = ~clk;

    wbu_commit #(.XLEN(32), .NREG(32), .BYPASS(1), .SB_W(2), .CAUSE_ECALL(11)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .rd(rd), .reg_en(reg_en),
        .wd(wd), .csr_rd(csr_rd), .csr_en(csr_en), .csr_wd(csr_wd), .ecall(ecall), .mret(mret),
        .ebreak(ebreak), .pc(pc), .pc_next(pc_next), .inst(inst), .iss_valid(iss_valid),
        .iss_rd(iss_rd), .iss_ready(iss_ready), .rs1(rs1), .rs2(rs2), .csr_rs(csr_rs),
        .rsa(rsa), .rsb(rsb), .csra(csra), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_pc_next(commit_pc_next),
        .commit_inst(commit_inst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted), .retire_cnt(retire_cnt)
    );

    wbu_commit #(.XLEN(32), .NREG(16), .BYPASS(1), .SB_W(2), .CAUSE_ECALL(11)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(x_in_ready), .rd(rd), .reg_en(reg_en),
        .wd(wd), .csr_rd(csr_rd), .csr_en(csr_en), .csr_wd(csr_wd), .ecall(ecall), .mret(mret),
        .ebreak(ebreak), .pc(pc), .pc_next(pc_next), .inst(inst), .iss_valid(iss_valid),
        .iss_rd(iss_rd), .iss_ready(x_iss_ready), .rs1(rs1), .rs2(rs2), .csr_rs(csr_rs),
        .rsa(x_rsa), .rsb(x_rsb), .csra(x_csra), .rs1_busy(x_rs1_busy), .rs2_busy(x_rs2_busy),
        .commit_valid(x_commit_valid), .commit_pc(x_commit_pc), .commit_pc_next(x_commit_pc_next),
        .commit_inst(x_commit_inst), .redirect_valid(x_redirect_valid), .redirect_pc(x_redirect_pc),
        .halted(x_halted), .retire_cnt(x_retire_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        in_valid = 0; reg_en = 0; rd = 0; wd = 0; csr_en = 0; csr_rd = 0; csr_wd = 0;
        ecall = 0; mret = 0; ebreak = 0; iss_valid = 0; iss_rd = 0;
    endtask

    task tick();
        @(posedge clk);
        #1;
    endtask

    task settle();
        #2;
    endtask

    task automatic accept_gpr(input logic [4:0] r, input logic [31:0] d);
        clr(); in_valid = 1; reg_en = 1; rd = r; wd = d;
    endtask

    task automatic issue(input logic [4:0] r);
        clr(); iss_valid = 1; iss_rd = r;
    endtask

    // Protocol monitor: the stimulus must never commit a register it did not issue.
    always @(posedge clk) begin
        if (rst) begin
            foreach (sb_model[i]) sb_model[i] = 0;
        end else begin
            if (in_valid && in_ready && reg_en && rd != 0) begin
                tests++;
                assert (sb_model[rd] > 0) else begin
                    failed++;
                    $error("FAIL sb_underflow: reg %0d count observed %0d required >0", rd, sb_model[rd]);
                end
            end
            if (iss_valid && iss_ready && iss_rd != 0) sb_model[iss_rd]++;
            if (in_valid && in_ready && reg_en && rd != 0 && sb_model[rd] > 0) sb_model[rd]--;
        end
    end

    initial begin
        clr(); rs1 = 0; rs2 = 0; csr_rs = 0; pc = 0; pc_next = 0; inst = 0;
        rst = 1;
        tick(); tick(); settle();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_iss_ready", iss_ready, 0);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_retire", retire_cnt, 0);
        rst = 0; settle();
        chk("run_in_ready", in_ready, 1);

        // Case 1: bypass and commit of x5
        issue(5); rs1 = 5; settle();
        chk("iss5_ready", iss_ready, 1);
        tick();
        accept_gpr(5, 32'h1234); pc = 32'h100; pc_next = 32'h104; inst = 32'h13; settle();
        chk("byp_rsa", rsa, 32'h1234);
        chk("busy_pre_update", rs1_busy, 1);
        tick(); clr(); settle();
        chk("x5_read", rsa, 32'h1234);
        chk("x5_busy_clear", rs1_busy, 0);
        chk("c1_commit_valid", commit_valid, 1);
        chk("c1_commit_pc", commit_pc, 32'h100);
        chk("c1_commit_pc_next", commit_pc_next, 32'h104);
        chk("c1_commit_inst", commit_inst, 32'h13);
        chk("c1_retire", retire_cnt, 1);
        tick(); settle();
        chk("c1_commit_drop", commit_valid, 0);
        chk("c1_commit_hold", commit_pc, 32'h100);

        // Case 2: x0 and out-of-range on the 16-register instance
        accept_gpr(0, 32'hFFFF_FFFF); rs1 = 0; settle();
        chk("x0_byp", rsa, 0);
        tick(); clr(); settle();
        chk("x0_read", rsa, 0);
        issue(20); tick();
        accept_gpr(20, 32'hABCD); rs1 = 20; settle();
        chk("x20_byp32", rsa, 32'hABCD);
        chk("x20_byp16", x_rsa, 0);
        tick(); clr(); settle();
        chk("x20_read32", rsa, 32'hABCD);
        chk("x20_read16", x_rsa, 0);
        chk("c2_retire", retire_cnt, 3);

        // Case 3: mtvec and mstatus setup, then ecall
        clr(); in_valid = 1; csr_en = 1; csr_rd = 3; csr_wd = 32'h8000_0100; csr_rs = 3; settle();
        chk("csr_byp", csra, 32'h8000_0100);
        tick();
        clr(); in_valid = 1; csr_en = 1; csr_rd = 2; csr_wd = 32'h8; tick();
        clr(); in_valid = 1; ecall = 1; pc = 32'h8000_0040; tick();
        clr(); csr_rs = 1; settle();
        chk("ecall_redirect_valid", redirect_valid, 1);
        chk("ecall_redirect_pc", redirect_pc, 32'h8000_0100);
        chk("ecall_mepc", csra, 32'h8000_0040);
        csr_rs = 0; settle();
        chk("ecall_mcause", csra, 11);
        csr_rs = 2; settle();
        chk("ecall_mstatus", csra, 32'h80);
        tick(); settle();
        chk("redirect_drop", redirect_valid, 0);

        // Case 4: mret
        clr(); in_valid = 1; mret = 1; tick();
        clr(); csr_rs = 2; settle();
        chk("mret_redirect_valid", redirect_valid, 1);
        chk("mret_redirect_pc", redirect_pc, 32'h8000_0040);
        chk("mret_mstatus", csra, 32'h88);
        chk("c4_retire", retire_cnt, 7);

        // Case 5: scoreboard saturation on x7
        rs1 = 7; rs2 = 7;
        for (int i = 0; i < 3; i++) begin
            issue(7); settle();
            chk("iss7_ready", iss_ready, 1);
            tick();
        end
        issue(7); settle();
        chk("iss7_full", iss_ready, 0);
        chk("x7_busy1", rs1_busy, 1);
        chk("x7_busy2", rs2_busy, 1);
        tick();
        accept_gpr(7, 32'h70); tick();
        accept_gpr(7, 32'h71); iss_valid = 1; iss_rd = 7; settle();
        chk("iss7_after_dec", iss_ready, 1);
        tick();
        accept_gpr(7, 32'h72); tick();
        clr(); settle();
        chk("x7_still_busy", rs1_busy, 1);
        accept_gpr(7, 32'h73); tick();
        clr(); settle();
        chk("x7_idle", rs1_busy, 0);
        chk("x7_value", rsa, 32'h73);
        chk("c5_retire", retire_cnt, 11);

        // Case 6: ebreak halt with in_valid held, then reset
        clr(); in_valid = 1; ebreak = 1; pc = 32'h200; settle();
        chk("ebreak_in_ready", in_ready, 1);
        tick(); settle();
        chk("halt_commit", commit_valid, 1);
        chk("halt_halted", halted, 1);
        chk("halt_in_ready", in_ready, 0);
        chk("halt_iss_ready", iss_ready, 0);
        chk("halt_retire", retire_cnt, 12);
        tick(); settle();
        chk("halt_commit_once", commit_valid, 0);
        chk("halt_retire_frozen", retire_cnt, 12);
        chk("halt_sticky", halted, 1);
        rst = 1; tick(); clr(); rs1 = 5; csr_rs = 3; settle();
        chk("rst2_halted", halted, 0);
        chk("rst2_retire", retire_cnt, 0);
        chk("rst2_commit_pc", commit_pc, 0);
        chk("rst2_redirect_pc", redirect_pc, 0);
        chk("rst2_x5", rsa, 0);
        chk("rst2_mtvec", csra, 0);
        chk("rst2_in_ready", in_ready, 0);
        rst = 0; settle();
        chk("rst2_run", in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
